// File: rtl/face_fetch_sequencer.sv
// Walks face memory once per frame, buffers returned faces in a 2-entry FIFO
// and hands them to the lighting stage over valid/ready with their index.
module face_fetch_sequencer #(
    parameter int FACES   = 92,
    parameter int ID_BITS = $clog2(FACES),
    parameter int FACE_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               loop,
    output logic [ID_BITS-1:0] mem_addr,
    output logic               mem_en,
    input  logic [FACE_W-1:0]  face_mem_data,
    output logic [FACE_W-1:0]  face_o,
    output logic [ID_BITS-1:0] face_id,
    output logic               face_valid,
    input  logic               face_ready,
    output logic               busy,
    output logic               frame_done,
    output logic [7:0]         frame_count
);

    localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(FACES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_reg;
    logic [ID_BITS-1:0] addr_reg;
    logic [ID_BITS-1:0] issue_addr_reg;
    logic               inflight_reg;
    logic               frame_done_reg;
    logic [7:0]         frame_count_reg;

    logic [FACE_W-1:0]  data_mem [2];
    logic [ID_BITS-1:0] id_mem   [2];
    logic               rd_ptr_reg;
    logic               wr_ptr_reg;
    logic [1:0]         count_reg;

    logic               pop;
    logic               push;
    logic               last_pop;
    logic [2:0]         occupancy;

    assign pop      = face_valid && face_ready;
    assign push     = inflight_reg;
    assign last_pop = pop && (face_id == LAST_ID);

    // Slots committed after this cycle's pop: buffered faces plus the read in flight.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign mem_en    = !reset && (state_reg == FETCH) && (occupancy < 3'd2);

    assign mem_addr    = addr_reg;
    assign face_valid  = (count_reg != 2'd0);
    assign face_o      = data_mem[rd_ptr_reg];
    assign face_id     = id_mem[rd_ptr_reg];
    assign busy        = (state_reg != IDLE);
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            issue_addr_reg  <= '0;
            inflight_reg    <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            inflight_reg   <= mem_en;
            frame_done_reg <= last_pop;
            if (last_pop) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
            if (mem_en) begin
                issue_addr_reg <= addr_reg;
                if (addr_reg != LAST_ID) begin
                    addr_reg <= addr_reg + ID_BITS'(1);
                end
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= FETCH;
                        addr_reg  <= '0;
                    end
                end
                FETCH: begin
                    if (mem_en && (addr_reg == LAST_ID)) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        if (loop) begin
                            state_reg <= FETCH;
                            addr_reg  <= '0;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            // The issue rule keeps capture from ever landing on a full buffer.
            assert (!(push && (count_reg == 2'd2) && !pop));
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                data_mem[gi] <= '0;
                id_mem[gi]   <= '0;
            end else if (push && (wr_ptr_reg == 1'(gi))) begin
                data_mem[gi] <= face_mem_data;
                id_mem[gi]   <= issue_addr_reg;
            end
        end
    end

endmodule

// File: doc/face_fetch_sequencer.md
Name: face_fetch_sequencer

Overview:
- Front-end controller for the graphics pipeline.
- On a start pulse (or continuously in loop mode), it walks the face memory from address 0 to FACES-1 and issues one synchronous read per face.
- It captures the returned face data into a 2-entry output buffer and presents faces to the lighting stage over a valid/ready handshake, with their face index attached.
- It replaces the free-running fetch counter so the downstream pipeline can apply backpressure without losing or duplicating faces.

Parameters:
- FACES, 92, number of faces in face memory; addresses 0..FACES-1.
- ID_BITS, $clog2(FACES), width of mem_addr and face_id.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one frame pass; sampled only in IDLE
- loop  in  1  when 1 at the end of a frame, start the next frame immediately
- mem_addr  out  ID_BITS  face memory read address
- mem_en  out  1  read strobe; face memory returns data the following cycle
- face_mem_data  in  Face_t  read data, valid the cycle after mem_en
- face_o  out  Face_t  face presented to the lighting stage
- face_id  out  ID_BITS  index of face_o
- face_valid  out  1  face_o/face_id valid
- face_ready  in  1  downstream accepts; transfer happens when face_valid && face_ready
- busy  out  1  high from the first FETCH cycle until the frame's last face is accepted
- frame_done  out  1  one-cycle pulse after the last face (id FACES-1) is accepted
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (synchronous, active-high): state=IDLE; mem_en=0, mem_addr=0, face_valid=0, face_id=0, face_o=0, busy=0, frame_done=0, frame_count=0. Buffer and in-flight flag are cleared. Reset mid-frame discards all buffered and in-flight data; the read returning after reset is ignored.
- States:
  - IDLE -> FETCH when start=1.
  - FETCH -> DRAIN the cycle after the read of address FACES-1 is issued.
  - DRAIN -> IDLE when the last face is accepted and loop=0.
  - DRAIN -> FETCH when the last face is accepted and loop=1; the address restarts at 0 and the next read is issued in the following cycle.
  - start is ignored outside IDLE.
- Issue rule (FETCH only):
  - mem_en=1 iff (buf_count + inflight - pop) < 2, where pop = face_valid && face_ready.
  - inflight = mem_en registered from the previous cycle.
  - mem_addr increments by 1 after each issued read and never exceeds FACES-1.
  - When mem_en=0, mem_addr holds its value.
- Capture: in the cycle after mem_en, face_mem_data and the registered issue address are written into the buffer (FIFO order). Capture and pop may happen in the same cycle.
- Output: face_valid = (buf_count != 0). face_o and face_id come from the buffer head and are stable while face_valid && !face_ready.
- Overflow is impossible by construction. A write into a full buffer is an assertion failure.
- Latency: start sampled in cycle 0 -> mem_en with addr 0 in cycle 1 -> face_valid with id 0 in cycle 3.
- Throughput: with face_ready held at 1, one face per cycle.
- busy: 1 in FETCH and DRAIN, 0 in IDLE.
- Frame end: frame_done pulses in the cycle after the id FACES-1 handshake; frame_count increments in the same cycle.
- In loop mode busy stays 1 across the frame boundary.

Test Plan:
- Single frame: reset, start pulse at cycle 0, face_ready=1 -> mem_addr 0..91 on cycles 1..92; face_id 0..91 on cycles 3..94 with matching data; frame_done pulse at cycle 95; frame_count=1; busy=0 at cycle 95.
- Backpressure: face_ready=0 for cycles 5..14 -> face_valid stays high with face_o/face_id frozen; mem_en drops once the buffer plus in-flight read reaches 2; ids are contiguous with no loss or duplicate; the frame completes 10 cycles later than in the first scenario.
- Random ready (50% toggle, 3 frames, loop=1) -> scoreboard sees ids 0..91 in order, 3 times; no IDLE cycle between frames; frame_count=3.
- Start while busy: start pulsed at cycle 40 of a frame -> ignored; exactly 92 faces and one frame_done.
- Reset mid-frame: reset asserted at cycle 30 for 1 cycle -> next cycle has face_valid=0, mem_en=0, busy=0, frame_count unchanged (0); the data returning from the cycle-29 read is ignored; a new start delivers id 0 first.
- Counter wrap: 256 looped frames with FACES=4 -> frame_count reaches 255 then 0; frame_done fires once per frame.
